// File: rtl/delay_pkg.sv
// Shared types and defaults for the sample-delay address/control path.
package delay_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 9;
  localparam logic [DATA_WIDTH_DEF-1:0] MIDSCALE_DEF = 9'h100;

  typedef enum logic [1:0] {IDLE, FILL, RUN} delay_state_t;

  // Midscale (silence) code for an unsigned-offset sample of width dw
  function automatic int midscale(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// 3-cycle per-strobe token pipe that travels alongside the RAM access.
// Optional DELAY_MIDSCALE_MUTE_EN: non-RUN strobes emit midscale instead of nothing.
module delay_pipe
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe_i,
  input  logic                  run_i,
  input  logic                  bypass_i,
  input  logic [DATA_WIDTH-1:0] bdata_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] sample_out_o
);

  logic [1:0]                  vld_q, run_q, byp_q;
  logic [1:0][DATA_WIDTH-1:0]  bdata_q;
  logic                        out_valid_q;
  logic [DATA_WIDTH-1:0]       sample_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q        <= '0;
      run_q        <= '0;
      byp_q        <= '0;
      bdata_q      <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
    end else begin
      vld_q       <= {vld_q[0], strobe_i};
      run_q       <= {run_q[0], run_i};
      byp_q       <= {byp_q[0], bypass_i};
      bdata_q     <= {bdata_q[0], bdata_i};
      out_valid_q <= 1'b0;
      // Stage 2 lines up with the RAM's registered read data
      if (vld_q[1]) begin
        if (run_q[1]) begin
          out_valid_q  <= 1'b1;
          sample_out_q <= byp_q[1] ? bdata_q[1] : dout_i;
        end
`ifdef DELAY_MIDSCALE_MUTE_EN
        else begin
          out_valid_q  <= 1'b1;
          sample_out_q <= DATA_WIDTH'(midscale(DATA_WIDTH));
        end
`endif
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign sample_out_o = sample_out_q;

endmodule

// File: rtl/delay_ctrl.sv
// Write/read pointer and fill-state control in front of a dual-port sample RAM.
// Optional DELAY_MIDSCALE_MUTE_EN (see delay_pipe) mutes to midscale while not RUN.
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic                  filling
);

  delay_state_t          state_q;
  logic [ADDR_WIDTH-1:0] wp_q, fill_cnt_q, offset_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  wr_en_q, rd_en_q, filling_q;

  logic                  restart, strobe_run;
  logic [ADDR_WIDTH-1:0] cnt_base;

  // A strobe counts as RUN once the history since the last (re)start covers
  // the offset; the check sees the strobe's own offset, so offset 0 runs at once.
  always_comb begin
    restart    = (state_q == IDLE) || (offset != offset_q);
    cnt_base   = restart ? '0 : fill_cnt_q;
    strobe_run = ((state_q == RUN) && !restart) || (cnt_base == offset);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      fill_cnt_q <= '0;
      offset_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      din_q      <= '0;
      filling_q  <= 1'b0;
    end else begin
      wr_en_q <= en;
      rd_en_q <= en;
      if (en) begin
        wr_addr_q <= wp_q;
        rd_addr_q <= wp_q - offset;
        din_q     <= sample_in;
        wp_q      <= wp_q + 1'b1;
        offset_q  <= offset;
        if (strobe_run) begin
          state_q    <= RUN;
          filling_q  <= 1'b0;
          fill_cnt_q <= '0;
        end else begin
          state_q    <= FILL;
          filling_q  <= 1'b1;
          fill_cnt_q <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
        end
      end
    end
  end

  delay_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .strobe_i    (en),
    .run_i       (strobe_run),
    .bypass_i    (offset == '0),
    .bdata_i     (sample_in),
    .dout_i      (dout),
    .out_valid_o (out_valid),
    .sample_out_o(sample_out)
  );

  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign wr_addr = wr_addr_q;
  assign rd_addr = rd_addr_q;
  assign din     = din_q;
  assign filling = filling_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Scoreboard bench for delay_ctrl with a behavioural 512x9 registered-read RAM.
// Honours DELAY_MIDSCALE_MUTE_EN when the design is built with it.
module tb_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [8:0] offset = '0;
  logic [8:0] sample_in = '0;
  logic       wr_en, rd_en, out_valid, filling;
  logic [8:0] wr_addr, rd_addr, din, dout, sample_out;

  logic [8:0] mem [512];
  logic [8:0] ram_dout = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] tb_wp = '0;

  typedef struct { logic [8:0] d; int cyc; } exp_out_t;
  typedef struct { logic [8:0] wa; logic [8:0] ra; logic [8:0] d; int cyc; } exp_acc_t;
  exp_out_t oq[$];
  exp_acc_t aq[$];

  delay_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .offset(offset), .sample_in(sample_in),
    .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .din(din),
    .dout(dout), .sample_out(sample_out), .out_valid(out_valid), .filling(filling)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    if (rd_en) ram_dout <= mem[rd_addr];
  end
  assign dout = ram_dout;

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ev: 1 = delayed output ed expected, 0 = still filling, 2 = aborted by reset
  task automatic strobe(input logic [8:0] s, input logic [8:0] off, input int ev,
                        input logic [8:0] ed);
    en = 1'b1; sample_in = s; offset = off;
    aq.push_back('{wa: tb_wp, ra: tb_wp - off, d: s, cyc: cyc + 1});
    tb_wp = tb_wp + 9'd1;
    if (ev == 1) oq.push_back('{d: ed, cyc: cyc + 3});
`ifdef DELAY_MIDSCALE_MUTE_EN
    else if (ev == 0) oq.push_back('{d: 9'h100, cyc: cyc + 3});
`endif
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tb_wp = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_en", {8'd0, wr_en}, 9'd0);
    chk("rst_rd_en", {8'd0, rd_en}, 9'd0);
    chk("rst_wr_addr", wr_addr, 9'd0);
    chk("rst_rd_addr", rd_addr, 9'd0);
    chk("rst_din", din, 9'd0);
    chk("rst_sample_out", sample_out, 9'd0);
    chk("rst_out_valid", {8'd0, out_valid}, 9'd0);
    chk("rst_filling", {8'd0, filling}, 9'd0);
  endtask

  task automatic monitor();
    exp_out_t e;
    exp_acc_t a;
    if (out_valid === 1'b1) begin
      checks++;
      if (oq.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected cyc=%0d got=%h", cyc, sample_out);
      end else begin
        e = oq.pop_front();
        if (sample_out !== e.d || cyc != e.cyc) begin
          failures++;
          $display("FAIL sample_out got=%h@%0d exp=%h@%0d", sample_out, cyc, e.d, e.cyc);
        end
      end
    end
    if (wr_en === 1'b1 || rd_en === 1'b1) begin
      checks++;
      if (aq.size() == 0) begin
        failures++;
        $display("FAIL ram_unexpected cyc=%0d wa=%h", cyc, wr_addr);
      end else begin
        a = aq.pop_front();
        if (wr_en !== 1'b1 || rd_en !== 1'b1 || wr_addr !== a.wa || rd_addr !== a.ra ||
            din !== a.d || cyc != a.cyc) begin
          failures++;
          $display("FAIL ram_access got wa=%h ra=%h din=%h@%0d exp wa=%h ra=%h din=%h@%0d",
                   wr_addr, rd_addr, din, cyc, a.wa, a.ra, a.d, a.cyc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none

    do_reset();
    chk_reset_vals();

    // offset 3: strobes 1..3 fill, then each output is the sample 3 strobes back
    strobe(9'd1, 9'd3, 0, 9'd0);
    chk("fill_rise", {8'd0, filling}, 9'd1);
    idle(3);
    for (int i = 2; i <= 8; i++) begin
      strobe(9'(i), 9'd3, (i >= 4) ? 1 : 0, 9'(i - 3));
      idle(3);
    end
    chk("fill_done", {8'd0, filling}, 9'd0);

    // zero-delay bypass
    strobe(9'h0AA, 9'd0, 1, 9'h0AA);
    idle(3);
    strobe(9'h155, 9'd0, 1, 9'h155);
    idle(3);

    // offset 4 refill, then change to 2 mid-stream
    for (int i = 0; i < 6; i++) strobe(9'h20 + 9'(i), 9'd4, (i >= 4) ? 1 : 0, 9'h20 + 9'(i - 4));
    strobe(9'h26, 9'd2, 0, 9'd0);
    chk("refill_rise", {8'd0, filling}, 9'd1);
    strobe(9'h27, 9'd2, 0, 9'd0);
    strobe(9'h28, 9'd2, 1, 9'h26);
    chk("refill_done", {8'd0, filling}, 9'd0);
    strobe(9'h29, 9'd2, 1, 9'h27);
    idle(4);

    // 600 back-to-back strobes across the pointer wrap
    for (int n = 0; n < 600; n++)
      strobe(9'(n % 512), 9'd5, (n >= 5) ? 1 : 0, 9'((n + 507) % 512));
    idle(4);

    // reset between a strobe and its output aborts the token
    strobe(9'h033, 9'd0, 2, 9'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_wp = '0;
    @(negedge clk);
    chk_reset_vals();
    idle(3);
    chk("idle_after_rst", {8'd0, filling}, 9'd0);

    // offset 3 from IDLE: three fill strobes (muted or silent), then first real output
    strobe(9'h011, 9'd3, 0, 9'd0);
    chk("idle_to_fill", {8'd0, filling}, 9'd1);
    strobe(9'h022, 9'd3, 0, 9'd0);
    strobe(9'h033, 9'd3, 0, 9'd0);
    strobe(9'h044, 9'd3, 1, 9'h011);
    idle(6);

    chk("out_queue_drained", 9'(oq.size()), 9'd0);
    chk("ram_queue_drained", 9'(aq.size()), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_ctrl.md
# delay_ctrl

- Address/control generator that sits directly upstream of the 512×9 dual-port sample RAM in the signal-generator delay path.
- On each sample strobe it writes the incoming sample at a free-running write pointer and reads the sample written `offset` strobes earlier.
- It then returns the RAM's registered read data as a delayed sample with a valid flag.
- A fill state machine suppresses output until the requested delay history exists.

## Interface
- `ADDR_WIDTH`, 9, RAM address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 9, sample width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: sample strobe, one-cycle pulse per sample.
- `offset` in ADDR_WIDTH: delay in samples, sampled only on `en`.
- `sample_in` in DATA_WIDTH: sample to store, sampled on `en`.
- `wr_en` out 1: RAM write enable.
- `rd_en` out 1: RAM read enable.
- `wr_addr` out ADDR_WIDTH: RAM write address.
- `rd_addr` out ADDR_WIDTH: RAM read address.
- `din` out DATA_WIDTH: RAM write data.
- `dout` in DATA_WIDTH: RAM registered read data, valid one cycle after `rd_en`.
- `sample_out` out DATA_WIDTH: delayed sample.
- `out_valid` out 1: one-cycle pulse, `sample_out` updated.
- `filling` out 1: high while in FILL.

## Operation
- Reset values (`rst_n`=0 at edge):
  - `wr_en`, `rd_en`, `out_valid`, `filling` = 0.
  - `wr_addr`, `rd_addr`, `din` = 0.
  - `sample_out` = 0.
  - Write pointer `wp` = 0, `fill_cnt` = 0, `offset_q` = 0, state = IDLE.
- Reset mid-operation aborts any in-flight pipeline token; no `out_valid` is issued for it.
- State machine:
  - IDLE → FILL on first `en`.
  - FILL → RUN when `fill_cnt` == `offset_q` at an `en`.
  - RUN → FILL when `en` arrives with `offset` ≠ `offset_q`.
  - FILL stays in FILL if `offset` changes; `fill_cnt` restarts.
- Per `en` (any state except IDLE→FILL transition also counts as a write):
  - Register `wr_en`=1, `wr_addr`=`wp`, `din`=`sample_in`.
  - Register `rd_en`=1, `rd_addr`=(`wp` − `offset`) mod 2^ADDR_WIDTH.
  - `wp` += 1, wrapping 511 → 0.
  - `offset_q` ← `offset`.
- `fill_cnt` increments per `en` in FILL, saturating at 2^ADDR_WIDTH−1; it resets to 0 on an offset change.
- `out_valid` pulses for a strobe only if the state at that strobe's `en` was RUN.
- `offset` = 0:
  - RAM read is still issued, but its data is ignored.
  - `sample_out` = the strobe's own `sample_in`, through the same pipeline depth; this is the zero-delay bypass.
  - FILL exits on the first `en` (`fill_cnt` 0 == 0).
- Read/write address collision occurs only for `offset` = 0 and is resolved by the bypass above.
- `en` asserted on consecutive cycles is legal.
  - Every strobe is pipelined independently at full rate.
  - No back-pressure.

## Timing
- Strobe at cycle t:
  - `wr_en`/`rd_en`/addresses valid in cycle t+1.
  - RAM `dout` valid in t+2.
  - `sample_out`/`out_valid` registered, valid in t+3.
  - Fixed latency 3 cycles.
- `wr_en`, `rd_en` are high exactly one cycle per strobe; low otherwise.
- `filling` is registered and reflects the state from the cycle after each transition.

## Configuration
- `DELAY_MIDSCALE_MUTE_EN`:
  - Defined: while not RUN, each strobe still produces `out_valid` with `sample_out` = 2^(DATA_WIDTH−1) (9'h100, midscale silence).
  - Undefined: no `out_valid` outside RUN, and `sample_out` holds its last value.

## Structure
- Shared package `delay_pkg`:
  - State enum `delay_state_t` {IDLE, FILL, RUN}.
  - `ADDR_WIDTH`/`DATA_WIDTH` defaults.
  - Midscale constant.
- One sub-module is natural: `delay_pipe`, the 3-stage valid/bypass/sample shift carrying per-strobe flags (run, bypass, bypass data) alongside the RAM access.
- The bench instantiates `delay_ctrl` with the existing RAM.

## Test plan
- Reset, then `offset`=3, strobes with samples 1..8 every 4 cycles:
  - The first 3 strobes give no `out_valid`.
  - Strobe 4 (sample 4) yields `sample_out`=1, 3 cycles after its `en`.
  - Subsequent outputs are 2, 3, 4, 5.
- `offset`=0, strobes 0x0AA, 0x155:
  - `sample_out` = 0x0AA, then 0x155, each at t+3.
  - No FILL delay beyond the first strobe.
- Wrap: `offset`=5, 600 back-to-back strobes with sample=index mod 512:
  - The output at strobe n equals (n−5) mod 512 across the `wp` 511→0 boundary.
  - `rd_addr` wraps correctly.
- In RUN with `offset`=4, change to 2 mid-stream:
  - `filling` rises.
  - Two strobes give no output.
  - Output then resumes with 2-sample delay.
- `rst_n` low for 1 cycle between a strobe and its t+3:
  - No `out_valid`.
  - All outputs at reset values.
  - IDLE on release.
- `offset`=3, 4 strobes:
  - With `DELAY_MIDSCALE_MUTE_EN` defined, strobes 1–3 give `out_valid` with 0x100.
  - Without it, strobes 1–3 give none.
